pc_sequencer: RTL and testbench
===============================

# pc_sequencer

Parametrised program-counter sequencer for the LC2K datapath. It holds the architectural PC and selects the next PC from sequential, BEQ-taken and JALR sources. It supports pipeline stalls, buffers a redirect that arrives during a stall, and implements a halt/resume state machine. It sits between decode/execute control and instruction memory, and counts PC advances for performance monitoring.

## Interface
- PC_WIDTH, 16: PC and address width; all PC arithmetic is modulo 2^PC_WIDTH.
- RESET_PC, 0: PC value loaded on reset.
- COUNT_WIDTH, 32: width of the advance counter.

- clk  input  1  single clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- stall  input  1  hold the PC this cycle.
- beq_taken  input  1  branch taken; target = beq_base + offset.
- beq_base  input  PC_WIDTH  PC+1 of the branch instruction.
- offset  input  32  sign-extended offsetField.
- jalr  input  1  jump; target = jalr_target.
- jalr_target  input  32  regA value.
- halt  input  1  enter HALTED.
- resume  input  1  leave HALTED.
- pc  output  PC_WIDTH  current PC, registered.
- pc_valid  output  1  1 only in RUN: pc is a new fetch address this cycle.
- halted  output  1  1 only in HALTED.
- redirect_pending  output  1  a buffered redirect is waiting.
- fetch_count  output  COUNT_WIDTH  number of PC updates since reset; wraps.

## Operation
- States: RUN, STALL, HALTED.
- redirect = beq_taken | jalr.
- Target selection:
  - beq_taken wins if both beq_taken and jalr are set.
  - BEQ target = (beq_base + offset[PC_WIDTH-1:0]) mod 2^PC_WIDTH.
  - JALR target = jalr_target[PC_WIDTH-1:0]; upper bits are ignored.
- Pending buffer: pend_valid plus pend_pc (PC_WIDTH).
- RUN or STALL, evaluated in priority order:
  1. halt=1: go to HALTED; pc holds; pending buffer cleared; stall and redirect ignored.
  2. stall=1: go to STALL; pc holds. If redirect, pend_pc <= target and pend_valid <= 1. A newer redirect overwrites the older one.
  3. Otherwise go to RUN and update pc as follows, then clear pend_valid and increment fetch_count:
     - redirect: pc <= target (a live redirect beats a pending one);
     - else pend_valid: pc <= pend_pc;
     - else pc <= pc + 1, wrapping at 2^PC_WIDTH.
- HALTED:
  - pc holds; stall, beq_taken, jalr and halt are ignored.
  - resume=1: go to RUN with pc unchanged; fetch_count unchanged.
- Outputs:
  - pc_valid = (state == RUN); halted = (state == HALTED).
  - redirect_pending = pend_valid.
  - All outputs come from registers; no combinational input-to-output path.
- Reset (asynchronous assert, any cycle, including mid-stall or while halted):
  - pc = RESET_PC; state RUN.
  - pc_valid = 1, halted = 0, redirect_pending = 0, fetch_count = 0.
  - Pending redirect discarded.

## Timing
- Latency: a redirect or sequential step sampled at edge N appears on pc after edge N; the new PC is presented the cycle after the request.
- Stall: pc is constant for every cycle stall is sampled high. On the first unstalled edge, pc takes the live redirect, else pend_pc, else pc+1.
- Halt: at most one cycle from halt sample to halted=1. With resume held from that cycle, the earliest return to RUN is the next edge.
- Simultaneous events:
  - halt and stall: halt wins.
  - halt and redirect: redirect is lost.
  - beq_taken and jalr: BEQ wins.
  - stall and redirect: the redirect is buffered, not applied.
- Wrap-around:
  - pc = 2^PC_WIDTH-1 stepping gives 0.
  - A negative offset that wraps below 0 gives the modular result.
  - fetch_count wraps to 0.

## Test plan
- Reset and stepping (PC_WIDTH=16, RESET_PC=0): release rst_n, run 3 cycles idle -> pc 0,1,2,3; fetch_count=3; pc_valid=1 throughout.
- BEQ backward branch: pc=10, beq_taken, beq_base=11, offset=0xFFFFFFFD -> next pc=8. Then beq_taken and jalr together with jalr_target=40 -> BEQ target chosen.
- Stall with redirect buffering:
  - At pc=5, stall=1 for 3 cycles; jalr with target 0x20 in the 2nd stall cycle -> pc stays 5, pc_valid=0, redirect_pending=1.
  - Release stall -> pc=0x20, redirect_pending=0.
  - Repeat with a live beq to 50 on the release cycle -> pc=50.
- Wrap: pc=0xFFFF stepping -> 0. jalr_target=0x0001_0007 -> pc=7.
- Halt/resume: halt with stall and beq at pc=9 -> halted=1, pc=9, redirect_pending=0. Toggle beq/stall while halted -> no change. resume -> RUN, pc=9, then 10.
- Async reset mid-stall: assert rst_n low between edges while pend_valid=1 -> outputs immediately pc=RESET_PC, redirect_pending=0, fetch_count=0. After release, stepping resumes from RESET_PC.

Source files
------------

// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: control/status bundle between decode/execute control and
// the PC sequencer.
//   master : drives stall/redirect/halt/resume requests, observes PC state
//   slave  : the sequencer itself
// Signals:
//   stall, beq_taken, beq_base, offset, jalr, jalr_target, halt, resume  (to sequencer)
//   pc, pc_valid, halted, redirect_pending, fetch_count                  (from sequencer)
interface pc_sequencer_if #(
   parameter int unsigned PC_WIDTH    = 16,
   parameter int unsigned COUNT_WIDTH = 32
);
   logic                   stall;
   logic                   beq_taken;
   logic [PC_WIDTH-1:0]    beq_base;
   logic [31:0]            offset;
   logic                   jalr;
   logic [31:0]            jalr_target;
   logic                   halt;
   logic                   resume;
   logic [PC_WIDTH-1:0]    pc;
   logic                   pc_valid;
   logic                   halted;
   logic                   redirect_pending;
   logic [COUNT_WIDTH-1:0] fetch_count;

   modport master (
      output stall, beq_taken, beq_base, offset, jalr, jalr_target, halt, resume,
      input  pc, pc_valid, halted, redirect_pending, fetch_count
   );

   modport slave (
      input  stall, beq_taken, beq_base, offset, jalr, jalr_target, halt, resume,
      output pc, pc_valid, halted, redirect_pending, fetch_count
   );
endinterface

// File: rtl/pc_sequencer.sv
// pc_sequencer: LC2K program-counter sequencer.
// Holds the architectural PC and picks the next PC from sequential, BEQ-taken
// and JALR sources; supports stalls, buffers a redirect seen during a stall,
// implements halt/resume and counts PC advances.
// Ports:
//   clk   : clock, all state updates on rising edge
//   rst_n : asynchronous active-low reset
//   bus   : pc_sequencer_if.slave (requests in, registered PC/status out)
module pc_sequencer #(
   parameter int unsigned         PC_WIDTH    = 16,
   parameter logic [PC_WIDTH-1:0] RESET_PC    = '0,
   parameter int unsigned         COUNT_WIDTH = 32
) (
   input logic             clk,
   input logic             rst_n,
   pc_sequencer_if.slave   bus
);

   typedef enum logic [1:0] {
      S_RUN,
      S_STALL,
      S_HALTED
   } state_t;

   state_t                 r_state;
   state_t                 w_state_nxt;
   logic [PC_WIDTH-1:0]    r_pc;
   logic [PC_WIDTH-1:0]    w_pc_nxt;
   logic [PC_WIDTH-1:0]    r_pend_pc;
   logic [PC_WIDTH-1:0]    w_pend_pc_nxt;
   logic                   r_pend_valid;
   logic                   w_pend_valid_nxt;
   logic [COUNT_WIDTH-1:0] r_count;
   logic [COUNT_WIDTH-1:0] w_count_nxt;
   logic [PC_WIDTH-1:0]    w_target;
   logic                   w_redirect;
   logic                   w_unused;

   // Upper bits of the 32-bit operands fall outside the PC address space.
   assign w_unused = ^{bus.offset[31:PC_WIDTH], bus.jalr_target[31:PC_WIDTH]};

   assign w_redirect = bus.beq_taken | bus.jalr;

   // BEQ has priority over JALR when both are asserted.
   assign w_target = bus.beq_taken ? (bus.beq_base + bus.offset[PC_WIDTH-1:0])
                                   : bus.jalr_target[PC_WIDTH-1:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= S_RUN;
         r_pc         <= RESET_PC;
         r_pend_pc    <= '0;
         r_pend_valid <= 1'b0;
         r_count      <= '0;
      end else begin
         r_state      <= w_state_nxt;
         r_pc         <= w_pc_nxt;
         r_pend_pc    <= w_pend_pc_nxt;
         r_pend_valid <= w_pend_valid_nxt;
         r_count      <= w_count_nxt;
      end
   end

   always_comb begin
      w_state_nxt      = r_state;
      w_pc_nxt         = r_pc;
      w_pend_pc_nxt    = r_pend_pc;
      w_pend_valid_nxt = r_pend_valid;
      w_count_nxt      = r_count;

      case (r_state)
         S_RUN, S_STALL: begin
            if (bus.halt) begin
               w_state_nxt      = S_HALTED;
               w_pend_valid_nxt = 1'b0;
            end else if (bus.stall) begin
               w_state_nxt = S_STALL;
               if (w_redirect) begin
                  w_pend_pc_nxt    = w_target;
                  w_pend_valid_nxt = 1'b1;
               end
            end else begin
               w_state_nxt = S_RUN;
               // Live redirect beats a buffered one, which beats sequential.
               if (w_redirect)
                  w_pc_nxt = w_target;
               else if (r_pend_valid)
                  w_pc_nxt = r_pend_pc;
               else
                  w_pc_nxt = r_pc + PC_WIDTH'(1);
               w_pend_valid_nxt = 1'b0;
               w_count_nxt      = r_count + COUNT_WIDTH'(1);
            end
         end
         S_HALTED: begin
            if (bus.resume)
               w_state_nxt = S_RUN;
         end
         default: begin
            w_state_nxt = S_RUN;
         end
      endcase
   end

   assign bus.pc               = r_pc;
   assign bus.pc_valid         = (r_state == S_RUN);
   assign bus.halted           = (r_state == S_HALTED);
   assign bus.redirect_pending = r_pend_valid;
   assign bus.fetch_count      = r_count;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed + randomized bench for pc_sequencer, checked
// against a flag-based behavioural model of the PC rules.
`timescale 1ns/1ps
module tb_pc_sequencer;

   localparam int unsigned PW = 16;
   localparam int unsigned CW = 8;
   localparam int unsigned PC_MASK  = (1 << PW) - 1;
   localparam int unsigned CNT_MASK = (1 << CW) - 1;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_errors;

   // reference model state
   int unsigned m_pc;
   int unsigned m_pend_pc;
   bit          m_pend;
   bit          m_halted;
   bit          m_stalled;
   int unsigned m_cnt;

   pc_sequencer_if #(.PC_WIDTH(PW), .COUNT_WIDTH(CW)) bus ();

   pc_sequencer #(
      .PC_WIDTH   (PW),
      .RESET_PC   (16'h0000),
      .COUNT_WIDTH(CW)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic check_all(input string tag);
      check({tag, ".pc"},       64'(bus.pc),               64'(m_pc));
      check({tag, ".valid"},    64'(bus.pc_valid),         64'(!m_halted && !m_stalled));
      check({tag, ".halted"},   64'(bus.halted),           64'(m_halted));
      check({tag, ".pending"},  64'(bus.redirect_pending), 64'(m_pend));
      check({tag, ".count"},    64'(bus.fetch_count),      64'(m_cnt));
   endtask

   task automatic model_reset();
      m_pc = 0; m_pend = 0; m_pend_pc = 0; m_halted = 0; m_stalled = 0; m_cnt = 0;
   endtask

   // One clock edge of the architectural rules, using the currently driven inputs.
   task automatic model_edge();
      int unsigned tgt;
      bit          redir;
      redir = bus.beq_taken || bus.jalr;
      if (bus.beq_taken) tgt = (int'(bus.beq_base) + bus.offset) & PC_MASK;
      else               tgt = bus.jalr_target & PC_MASK;
      if (m_halted) begin
         if (bus.resume) begin
            m_halted = 0;
            m_stalled = 0;
         end
      end else if (bus.halt) begin
         m_halted = 1;
         m_pend = 0;
      end else if (bus.stall) begin
         m_stalled = 1;
         if (redir) begin
            m_pend = 1;
            m_pend_pc = tgt;
         end
      end else begin
         m_stalled = 0;
         if (redir)       m_pc = tgt;
         else if (m_pend) m_pc = m_pend_pc;
         else             m_pc = (m_pc + 1) & PC_MASK;
         m_pend = 0;
         m_cnt = (m_cnt + 1) & CNT_MASK;
      end
   endtask

   task automatic drive(input bit st, input bit bq, input int unsigned base,
                        input int unsigned off, input bit jl, input int unsigned jt,
                        input bit hl, input bit rs);
      bus.stall       = st;
      bus.beq_taken   = bq;
      bus.beq_base    = PW'(base);
      bus.offset      = off;
      bus.jalr        = jl;
      bus.jalr_target = jt;
      bus.halt        = hl;
      bus.resume      = rs;
   endtask

   task automatic idle();
      drive(0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic tick(input string tag);
      @(posedge clk);
      model_edge();
      #1;
      check_all(tag);
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      rst_n = 1'b0;
      idle();
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_all("reset");
      rst_n = 1'b1;

      // sequential stepping from RESET_PC
      for (int i = 0; i < 3; i++) tick("step");
      check("step3.pc", 64'(bus.pc), 64'd3);
      check("step3.cnt", 64'(bus.fetch_count), 64'd3);

      // backward BEQ, then BEQ+JALR together
      drive(0, 0, 0, 0, 1, 10, 0, 0); tick("jalr10");
      drive(0, 1, 11, 32'hFFFF_FFFD, 0, 0, 0, 0); tick("beq_back");
      check("beq_back.abs", 64'(bus.pc), 64'd8);
      drive(0, 1, 9, 5, 1, 40, 0, 0); tick("beq_wins");
      check("beq_wins.abs", 64'(bus.pc), 64'd14);

      // stall with buffered JALR
      drive(0, 0, 0, 0, 1, 5, 0, 0); tick("to5");
      drive(1, 0, 0, 0, 0, 0, 0, 0); tick("stall1");
      drive(1, 0, 0, 0, 1, 32'h20, 0, 0); tick("stall2");
      drive(1, 0, 0, 0, 0, 0, 0, 0); tick("stall3");
      check("stall3.pc", 64'(bus.pc), 64'd5);
      check("stall3.pend", 64'(bus.redirect_pending), 64'd1);
      idle(); tick("release");
      check("release.pc", 64'(bus.pc), 64'h20);

      // buffered redirect overridden by live BEQ on release
      drive(1, 0, 0, 0, 1, 32'h30, 0, 0); tick("stall_b");
      drive(0, 1, 50, 0, 0, 0, 0, 0); tick("live_beats_pend");
      check("live.pc", 64'(bus.pc), 64'd50);

      // wrap-around
      drive(0, 0, 0, 0, 1, 32'hFFFF, 0, 0); tick("toFFFF");
      idle(); tick("wrap");
      check("wrap.pc", 64'(bus.pc), 64'd0);
      drive(0, 0, 0, 0, 1, 32'h0001_0007, 0, 0); tick("jalr_trunc");
      check("jalr_trunc.pc", 64'(bus.pc), 64'd7);

      // halt with stall and beq, ignored inputs, resume
      drive(0, 0, 0, 0, 1, 9, 0, 0); tick("to9");
      drive(1, 0, 0, 0, 1, 3, 0, 0); tick("pend_before_halt");
      drive(1, 1, 20, 4, 0, 0, 1, 0); tick("halt");
      check("halt.halted", 64'(bus.halted), 64'd1);
      drive(1, 1, 30, 1, 0, 0, 0, 0); tick("halted_beq");
      drive(0, 0, 0, 0, 1, 77, 1, 0); tick("halted_jalr");
      drive(0, 0, 0, 0, 0, 0, 0, 1); tick("resume");
      check("resume.pc", 64'(bus.pc), 64'd9);
      idle(); tick("after_resume");
      check("after_resume.pc", 64'(bus.pc), 64'd10);

      // asynchronous reset between edges while a redirect is pending
      drive(1, 0, 0, 0, 1, 99, 0, 0); tick("pend_for_rst");
      #3;
      rst_n = 1'b0;
      model_reset();
      #1;
      check_all("async_rst");
      idle();
      @(posedge clk);
      #1;
      check_all("rst_hold");
      rst_n = 1'b1;
      tick("post_rst");
      check("post_rst.pc", 64'(bus.pc), 64'd1);

      // randomized traffic
      for (int i = 0; i < 600; i++) begin
         int unsigned off;
         off = ($urandom_range(0, 1) == 1) ? $urandom() : ($urandom_range(0, 15) - 8);
         drive($urandom_range(0, 99) < 30, $urandom_range(0, 99) < 15,
               $urandom_range(0, PC_MASK), off,
               $urandom_range(0, 99) < 15, $urandom(),
               $urandom_range(0, 99) < 5, $urandom_range(0, 99) < 30);
         tick("rand");
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
